// File: rtl/cmd_dispatcher_pkg.sv
// Shared field layout, payload types and FSM encoding for the command dispatcher.
package cmd_dispatcher_pkg;

  localparam int INSTR_LSB  = 0;
  localparam int INSTR_W    = 8;
  localparam int MODSEL_LSB = 8;
  localparam int MODSEL_W   = 1;
  localparam int RDM0_LSB   = 9;
  localparam int RDM1_LSB   = 13;
  localparam int WTM0_LSB   = 17;
  localparam int WTM1_LSB   = 21;
  localparam int MEMSEL_W   = 4;
  localparam int FIELDS_W   = 25;

  // Bits [24:0] of a command word; [31:25] are carried only in cmd_t.
  typedef struct packed {
    logic [MEMSEL_W-1:0] wt_m1;
    logic [MEMSEL_W-1:0] wt_m0;
    logic [MEMSEL_W-1:0] rd_m1;
    logic [MEMSEL_W-1:0] rd_m0;
    logic [MODSEL_W-1:0] modulus_sel;
    logic [INSTR_W-1:0]  instruction;
  } cmd_fields_t;

  typedef struct packed {
    logic [31-FIELDS_W:0] rsvd;
    cmd_fields_t          f;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    RELEASE   = 2'd3
  } state_t;

  localparam cmd_fields_t NO_CMD = cmd_fields_t'({FIELDS_W{1'b0}});

  function automatic logic is_nop(input cmd_fields_t c);
    return (c.instruction == 8'h00);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO: registered storage, combinational head, single-cycle flush.
module cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ZERO = {(AW+1){1'b0}};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == CNT_ZERO);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // A flush discards the queue and any push presented in the same cycle.
  always_comb begin
    mem_d   = mem_q;
    push_ok = push && !full && !flush;
    pop_ok  = pop && !empty;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
    end else begin
      mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
    end
    if (flush) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = CNT_ZERO;
    end else begin
      wr_ptr_d = push_ok ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
      rd_ptr_d = pop_ok  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
      count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= CNT_ZERO;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: only entries below count are ever popped.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/cmd_dispatcher.sv
// Queues host command words and issues them one at a time on the coprocessor bus,
// holding each until done, with a completion counter and a sticky watchdog flag.
module cmd_dispatcher
  import cmd_dispatcher_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1048576
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            cmd_data,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   flush,
  input  logic                   clr_err,
  input  logic                   done,
  output logic [7:0]             instruction,
  output logic                   modulus_sel,
  output logic [3:0]             rdM0,
  output logic [3:0]             rdM1,
  output logic [3:0]             wtM0,
  output logic [3:0]             wtM1,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [31:0]            cmd_completed,
  output logic                   timeout_err
);

  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam bit          WD_EN   = (TIMEOUT != 0);
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT - 1);

  cmd_t                cmd_in;
  logic                cmd_unused;
  logic [FIELDS_W-1:0] fifo_head_raw;
  cmd_fields_t         fifo_head;
  logic [CW-1:0]       fifo_cnt;
  logic                fifo_full, fifo_empty, fifo_pop;

  state_t      state_q, state_d;
  cmd_fields_t cmd_q, cmd_d;
  cmd_fields_t out_q, out_d;
  logic [31:0] wdog_q, wdog_d;
  logic [31:0] completed_q, completed_d;
  logic        err_q, err_d, err_set;

  assign cmd_in     = cmd_t'(cmd_data);
  assign cmd_unused = ^cmd_in.rsvd;
  assign fifo_head  = cmd_fields_t'(fifo_head_raw);

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FIELDS_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cmd_valid),
    .push_data (cmd_in.f),
    .pop       (fifo_pop),
    .flush     (flush),
    .head      (fifo_head_raw),
    .count     (fifo_cnt),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Next state, payload latching, watchdog and completion counting.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    out_d       = out_q;
    wdog_d      = wdog_q;
    completed_d = completed_q;
    fifo_pop    = 1'b0;
    err_set     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cmd_d    = fifo_head;
          if (is_nop(fifo_head)) begin
            completed_d = completed_q + 32'd1;
          end else begin
            state_d = ISSUE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        out_d   = cmd_q;
        wdog_d  = 32'd0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done) begin
          completed_d = completed_q + 32'd1;
          out_d       = NO_CMD;
          state_d     = RELEASE;
        end else if (WD_EN && (wdog_q == WD_LAST)) begin
          err_set = 1'b1;
          out_d   = NO_CMD;
          state_d = RELEASE;
        end else begin
          wdog_d = wdog_q + 32'd1;
        end
      end
      RELEASE: begin
        state_d = done ? RELEASE : IDLE;
      end
      default: begin
        out_d   = NO_CMD;
        state_d = IDLE;
      end
    endcase
    err_d = err_set ? 1'b1 : (clr_err ? 1'b0 : err_q);
  end

  // Reset drops any in-flight command so the bus idles on the following cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_q       <= NO_CMD;
      out_q       <= NO_CMD;
      wdog_q      <= 32'd0;
      completed_q <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      out_q       <= out_d;
      wdog_q      <= wdog_d;
      completed_q <= completed_d;
      err_q       <= err_d;
    end
  end

  assign cmd_ready     = !fifo_full;
  assign fifo_count    = fifo_cnt;
  assign busy          = (state_q != IDLE) || !fifo_empty;
  assign instruction   = out_q.instruction;
  assign modulus_sel   = out_q.modulus_sel;
  assign rdM0          = out_q.rd_m0;
  assign rdM1          = out_q.rd_m1;
  assign wtM0          = out_q.wt_m0;
  assign wtM1          = out_q.wt_m1;
  assign cmd_completed = completed_q;
  assign timeout_err   = err_q;

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Bench for cmd_dispatcher: table-driven field vectors, directed corner sequences,
// and a randomized run against a queue-based reference model.
module tb_cmd_dispatcher;
  import cmd_dispatcher_pkg::*;

  localparam int DEPTH = 8;
  localparam int TO_A  = 16;
  localparam int P_IDLE = 0, P_PENDING = 1, P_ACTIVE = 2, P_DRAIN = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cmd_data = 32'd0;
  logic        cmd_valid = 1'b0, flush = 1'b0, clr_err = 1'b0, done = 1'b0;

  logic        cmd_ready_a, modulus_sel_a, busy_a, timeout_err_a;
  logic [7:0]  instruction_a;
  logic [3:0]  rdm0_a, rdm1_a, wtm0_a, wtm1_a, fifo_count_a;
  logic [31:0] cmd_completed_a;
  logic        cmd_ready_b, modulus_sel_b, busy_b, timeout_err_b;
  logic [7:0]  instruction_b;
  logic [3:0]  rdm0_b, rdm1_b, wtm0_b, wtm1_b, fifo_count_b;
  logic [31:0] cmd_completed_b;

  always #5 clk = ~clk;

  cmd_dispatcher #(.DEPTH(DEPTH), .TIMEOUT(TO_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready_a), .flush(flush), .clr_err(clr_err), .done(done),
    .instruction(instruction_a), .modulus_sel(modulus_sel_a),
    .rdM0(rdm0_a), .rdM1(rdm1_a), .wtM0(wtm0_a), .wtM1(wtm1_a),
    .busy(busy_a), .fifo_count(fifo_count_a), .cmd_completed(cmd_completed_a),
    .timeout_err(timeout_err_a)
  );

  cmd_dispatcher #(.DEPTH(DEPTH), .TIMEOUT(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready_b), .flush(flush), .clr_err(clr_err), .done(done),
    .instruction(instruction_b), .modulus_sel(modulus_sel_b),
    .rdM0(rdm0_b), .rdM1(rdm1_b), .wtM0(wtm0_b), .wtM1(wtm1_b),
    .busy(busy_b), .fifo_count(fifo_count_b), .cmd_completed(cmd_completed_b),
    .timeout_err(timeout_err_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; flush = 1'b0; clr_err = 1'b0; done = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] pack_a();
    return {fifo_count_a, timeout_err_a, busy_a, cmd_ready_a,
            wtm1_a, wtm0_a, rdm1_a, rdm0_a, modulus_sel_a, instruction_a};
  endfunction

  function automatic logic [31:0] pack_b();
    return {fifo_count_b, timeout_err_b, busy_b, cmd_ready_b,
            wtm1_b, wtm0_b, rdm1_b, rdm0_b, modulus_sel_b, instruction_b};
  endfunction

  // Expected output bundle for a command word shown on the bus, decoded from the word layout.
  function automatic logic [31:0] exp_pack(input logic [31:0] w, input logic [3:0] cnt,
                                           input logic err, input logic bsy, input logic rdy);
    logic [INSTR_W-1:0]  ins;
    logic [MODSEL_W-1:0] ms;
    logic [MEMSEL_W-1:0] r0, r1, w0, w1;
    ins = w[INSTR_LSB +: INSTR_W];
    ms  = w[MODSEL_LSB +: MODSEL_W];
    r0  = w[RDM0_LSB +: MEMSEL_W];
    r1  = w[RDM1_LSB +: MEMSEL_W];
    w0  = w[WTM0_LSB +: MEMSEL_W];
    w1  = w[WTM1_LSB +: MEMSEL_W];
    return {cnt, err, bsy, rdy, w1, w0, r1, r0, ms, ins};
  endfunction

  // Reference model: a queue of pending words and the life-cycle phase of the current one.
  logic [31:0] m_q[$];
  int          m_ph;
  logic [31:0] m_cur;
  int          m_wait;
  logic [31:0] m_done_cnt;
  bit          m_err;

  task automatic model_reset();
    m_q.delete(); m_ph = P_IDLE; m_cur = 32'd0; m_wait = 0; m_done_cnt = 32'd0; m_err = 1'b0;
  endtask

  task automatic model_step();
    bit accept, set_err;
    if (!rst_n) begin
      model_reset();
      return;
    end
    accept  = cmd_valid && (m_q.size() < DEPTH);
    set_err = 1'b0;
    case (m_ph)
      P_IDLE: if (m_q.size() != 0) begin
        m_cur = m_q.pop_front();
        if (m_cur[INSTR_LSB +: INSTR_W] == 8'h00) m_done_cnt = m_done_cnt + 32'd1;
        else m_ph = P_PENDING;
      end
      P_PENDING: begin m_ph = P_ACTIVE; m_wait = 0; end
      P_ACTIVE: begin
        m_wait++;
        if (done) begin m_done_cnt = m_done_cnt + 32'd1; m_ph = P_DRAIN; end
        else if (m_wait == TO_A) begin set_err = 1'b1; m_ph = P_DRAIN; end
      end
      P_DRAIN: if (!done) m_ph = P_IDLE;
      default: m_ph = P_IDLE;
    endcase
    if (flush) m_q.delete();
    else if (accept) m_q.push_back(cmd_data);
    if (set_err) m_err = 1'b1;
    else if (clr_err) m_err = 1'b0;
  endtask

  function automatic logic [31:0] model_pack();
    logic [31:0] shown;
    shown = (m_ph == P_ACTIVE) ? m_cur : 32'd0;
    return exp_pack(shown, 4'(m_q.size()), m_err,
                    (m_ph != P_IDLE) || (m_q.size() != 0), m_q.size() < DEPTH);
  endfunction

  typedef struct {
    logic [31:0] word;
    logic [7:0]  instr;
    logic        mods;
    logic [3:0]  r0, r1, w0, w1;
  } vec_t;

  vec_t        vecs [4];
  logic [31:0] seq[$];
  logic [7:0]  prev;
  int          accepted, hi, bad, overlap, p_done;
  bit          acc;

  initial begin
    vecs[0] = '{32'h00000014, 8'h14, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[1] = '{32'h01FFFF01, 8'h01, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF};
    vecs[2] = '{32'h012B86A5, 8'hA5, 1'b0, 4'h3, 4'hC, 4'h5, 4'h9};
    vecs[3] = '{32'hFE000142, 8'h42, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0};

    do_reset();
    check("reset_a", pack_a(), 32'h02000000);
    check("reset_b", pack_b(), 32'h02000000);
    check("reset_completed", cmd_completed_a, 32'd0);

    // Field mapping and issue latency, one command at a time.
    for (int i = 0; i < 4; i++) begin
      cmd_data = vecs[i].word; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      check("lat_accept", {24'd0, instruction_a}, 32'd0);
      tick();
      check("lat_pop", {24'd0, instruction_a}, 32'd0);
      tick();
      check("fields", pack_a(), {4'd0, 1'b0, 1'b1, 1'b1, vecs[i].w1, vecs[i].w0,
                                 vecs[i].r1, vecs[i].r0, vecs[i].mods, vecs[i].instr});
      tick(); tick(); tick();
      check("hold", {24'd0, instruction_a}, {24'd0, vecs[i].instr});
      done = 1'b1;
      tick();
      check("release", {24'd0, instruction_a}, 32'd0);
      tick(); tick();
      done = 1'b0;
      tick(); tick();
      check("completed", cmd_completed_a, 32'(i + 1));
      check("idle_busy", {31'd0, busy_a}, 32'd0);
    end

    // Backpressure on the watchdog-free instance.
    do_reset();
    accepted = 0;
    for (int c = 0; c < 14; c++) begin
      cmd_valid = (accepted < 10);
      cmd_data  = 32'(accepted + 1);
      acc = cmd_valid && cmd_ready_b;
      tick();
      if (acc) accepted++;
    end
    cmd_valid = 1'b0;
    check("bp_accepted", 32'(accepted), 32'd9);
    check("bp_count", {28'd0, fifo_count_b}, 32'd8);
    check("bp_ready", {31'd0, cmd_ready_b}, 32'd0);
    seq.delete();
    prev = 8'h00;
    for (int c = 0; c < 60; c++) begin
      if (instruction_b != 8'h00 && prev == 8'h00) seq.push_back({24'd0, instruction_b});
      prev = instruction_b;
      done = (instruction_b != 8'h00);
      tick();
    end
    done = 1'b0;
    check("bp_issued", 32'(seq.size()), 32'd9);
    for (int k = 0; k < seq.size() && k < 9; k++) check("bp_order", seq[k], 32'(k + 1));
    check("bp_completed", cmd_completed_b, 32'd9);

    // Watchdog timeout and sticky error clear.
    do_reset();
    cmd_data = 32'h00000033; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    hi = 0; overlap = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (instruction_a == 8'h33) hi++;
      if (instruction_a == 8'h33 && timeout_err_a) overlap++;
    end
    check("to_cycles", 32'(hi), 32'd16);
    check("to_overlap", 32'(overlap), 32'd0);
    check("to_state", pack_a(), 32'h0A000000);
    check("to_completed", cmd_completed_a, 32'd0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("to_clear", {31'd0, timeout_err_a}, 32'd0);

    // Flush while a command is in flight, then a NOP.
    do_reset();
    cmd_data = 32'h00000021; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    check("fl_issue", {24'd0, instruction_a}, 32'h21);
    for (int k = 0; k < 3; k++) begin
      cmd_data = 32'(8'h22 + k); cmd_valid = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    check("fl_queued", {28'd0, fifo_count_a}, 32'd3);
    flush = 1'b1; cmd_valid = 1'b1; cmd_data = 32'h00000025;
    tick();
    flush = 1'b0; cmd_valid = 1'b0;
    check("fl_count", {28'd0, fifo_count_a}, 32'd0);
    check("fl_inflight", {24'd0, instruction_a}, 32'h21);
    done = 1'b1;
    tick();
    done = 1'b0;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (instruction_a != 8'h00) bad++;
    end
    check("fl_no_issue", 32'(bad), 32'd0);
    check("fl_completed", cmd_completed_a, 32'd1);
    cmd_data = 32'h00000000; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      if (instruction_a != 8'h00) bad++;
      tick();
    end
    check("nop_no_issue", 32'(bad), 32'd0);
    check("nop_completed", cmd_completed_a, 32'd2);

    // Reset while waiting for done with four commands queued.
    for (int k = 0; k < 5; k++) begin
      cmd_data = 32'(8'h41 + k); cmd_valid = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    tick();
    check("rm_pre_instr", {24'd0, instruction_a}, 32'h41);
    check("rm_pre_count", {28'd0, fifo_count_a}, 32'd4);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rm_state_a", pack_a(), 32'h02000000);
    check("rm_state_b", pack_b(), 32'h02000000);
    check("rm_completed", cmd_completed_a, 32'd0);

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      p_done    = (((cyc / 500) % 2) == 0) ? 3 : 12;
      rst_n     = ($urandom_range(0, 599) != 0);
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_data  = $urandom;
      if ($urandom_range(0, 4) == 0) cmd_data[7:0] = 8'h00;
      done      = ($urandom_range(0, p_done - 1) == 0);
      flush     = ($urandom_range(0, 39) == 0);
      clr_err   = ($urandom_range(0, 15) == 0);
      model_step();
      tick();
      check("rand_outputs", pack_a(), model_pack());
      check("rand_completed", cmd_completed_a, m_done_cnt);
    end
    rst_n = 1'b1; cmd_valid = 1'b0; done = 1'b0; flush = 1'b0; clr_err = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, limit 1000000 reached");
    $fatal(1, "bench time limit exceeded");
  end

endmodule
